// File: rtl/decoder_1hot_seq.sv
// rtl/decoder_1hot_seq.sv - registered one-hot decoder with valid/ready accept and optional scan walk
// Scan mode (SCAN state, dwell counter, wrap pulse) is compiled in with DECODER_1HOT_SCAN_EN.
module decoder_1hot_seq #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      in,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(2**IN_W)-1:0] out,
  output logic [IN_W-1:0]      out_idx,
  output logic                 out_valid,
  output logic                 wrap
);
  localparam int OUT_W = 2**IN_W;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SCAN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] idx, idx_nxt;
  logic            accept;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state != IDLE);
  assign out_idx   = idx;
  assign out       = out_valid ? (OUT_W'(1) << idx) : '0;

`ifdef DECODER_1HOT_SCAN_EN
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               wrap_q, wrap_nxt;

  assign in_ready = (state != SCAN);
  assign wrap     = wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    case (state)
      SCAN: begin
        // Leaving scan takes precedence over a pending step, so no wrap can fire on exit.
        if (!mode) begin
          state_nxt = HOLD;
        end else if (cnt == '0) begin
          idx_nxt  = idx + 1'b1;
          cnt_nxt  = dwell;
          wrap_nxt = (idx == '1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        if (accept) begin
          idx_nxt = in;
          if (mode) begin
            state_nxt = SCAN;
            cnt_nxt   = dwell;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
    endcase
  end
`else
  logic unused_scan_inputs;

  assign in_ready           = 1'b1;
  assign wrap               = 1'b0;
  assign unused_scan_inputs = ^{mode, dwell};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (accept) begin
      state_nxt = HOLD;
      idx_nxt   = in;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_1hot_seq.sv
// tb/tb_decoder_1hot_seq.sv - self-checking bench for decoder_1hot_seq against an arithmetic reference
// Scan scenarios run only when DECODER_1HOT_SCAN_EN is defined.
module tb_decoder_1hot_seq;
  localparam int IN_W    = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 8;
`ifdef DECODER_1HOT_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [IN_W-1:0]    in;
  logic               in_ready;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic [IN_W-1:0]    out_idx;
  logic               out_valid;
  logic               wrap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_1hot_seq #(.IN_W(IN_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .in_ready(in_ready),
    .mode(mode), .dwell(dwell), .out(out), .out_idx(out_idx),
    .out_valid(out_valid), .wrap(wrap)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] onehot(input int p);
    logic [OUT_W-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in = 3'd3; mode = 1'b0; dwell = '0;
    tick;
    tick;
    n_cmp++;
    if (out !== '0 || out_idx !== '0 || out_valid !== 1'b0 || wrap !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: out=%h idx=%0d valid=%b wrap=%b ready=%b, need 00/0/0/0/1",
               out, out_idx, out_valid, wrap, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick;
    n_cmp++;
    if (out !== '0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: out=%h valid=%b, need 00/0", out, out_valid);
    end
  endtask

  task automatic test_decode;
    int exp_idx;
    for (int i = 0; i < OUT_W; i++) begin
      in_valid = 1'b1; in = IN_W'(i); mode = 1'b0;
      tick;
      n_cmp++;
      if (out !== onehot(i) || out_idx !== IN_W'(i) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL decode_seq[%0d]: out=%h idx=%0d valid=%b ready=%b, need %h/%0d/1/1",
                 i, out, out_idx, out_valid, in_ready, onehot(i), i);
      end
    end
    exp_idx = OUT_W - 1;
    repeat (40) begin
      in_valid = 1'($urandom_range(0, 1));
      in       = IN_W'($urandom);
      mode     = SCAN_EN ? 1'b0 : 1'($urandom_range(0, 1));
      dwell    = DWELL_W'($urandom);
      if (in_valid) exp_idx = int'(in);
      tick;
      n_cmp++;
      if (out !== onehot(exp_idx) || out_idx !== IN_W'(exp_idx) || out_valid !== 1'b1 ||
          wrap !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL decode_rand: out=%h idx=%0d valid=%b wrap=%b ready=%b, need %h/%0d/1/0/1",
                 out, out_idx, out_valid, wrap, in_ready, onehot(exp_idx), exp_idx);
      end
    end
    in_valid = 1'b0;
  endtask

  // Scan from s with constant dwell d; mode drops at edge e after the accept edge.
  // After edge k the position is s + k/(d+1) (mod OUT_W); steps land on k % (d+1) == 0.
  task automatic test_scan(input string name, input int s, input int d, input int e);
    int pos;
    bit exp_wrap;
    in_valid = 1'b1; in = IN_W'(s); mode = 1'b1; dwell = DWELL_W'(d);
    tick;
    n_cmp++;
    if (out !== onehot(s) || out_idx !== IN_W'(s) || out_valid !== 1'b1 || in_ready !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_start: out=%h idx=%0d valid=%b ready=%b wrap=%b, need %h/%0d/1/0/0",
               name, out, out_idx, out_valid, in_ready, wrap, onehot(s), s);
    end
    for (int k = 1; k <= e; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in       = IN_W'($urandom);
      mode     = (k != e);
      tick;
      if (k < e) begin
        pos      = (s + k / (d + 1)) % OUT_W;
        exp_wrap = (k % (d + 1) == 0) && (pos == 0);
      end else begin
        pos      = (s + (k - 1) / (d + 1)) % OUT_W;
        exp_wrap = 1'b0;
      end
      n_cmp++;
      if (out !== onehot(pos) || out_idx !== IN_W'(pos) || out_valid !== 1'b1 ||
          wrap !== exp_wrap || in_ready !== (k == e)) begin
        n_bad++;
        $display("FAIL %s k=%0d: out=%h idx=%0d valid=%b wrap=%b ready=%b, need %h/%0d/1/%b/%b",
                 name, k, out, out_idx, out_valid, wrap, in_ready, onehot(pos), pos, exp_wrap, k == e);
      end
    end
    in_valid = 1'b0; mode = 1'b0;
    tick;
    pos = (s + (e - 1) / (d + 1)) % OUT_W;
    n_cmp++;
    if (out !== onehot(pos) || wrap !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_hold: out=%h wrap=%b ready=%b, need %h/0/1", name, out, wrap, in_ready, onehot(pos));
    end
  endtask

  task automatic test_reset_mid_scan;
    in_valid = 1'b1; in = 3'd7; mode = 1'b1; dwell = 8'd1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    n_cmp++;
    if (out !== '0 || out_idx !== '0 || out_valid !== 1'b0 || wrap !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_scan: out=%h idx=%0d valid=%b wrap=%b ready=%b, need 00/0/0/0/1",
               out, out_idx, out_valid, wrap, in_ready);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (out_valid !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_scan_after: valid=%b wrap=%b, need 0/0", out_valid, wrap);
    end
  endtask

  task automatic test_no_scan;
    in_valid = 1'b1; in = 3'd5; mode = 1'b1; dwell = DWELL_W'($urandom);
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (out !== 8'h20 || out_idx !== 3'd5 || out_valid !== 1'b1 || wrap !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL no_scan k=%0d: out=%h idx=%0d valid=%b wrap=%b ready=%b, need 20/5/1/0/1",
                 k, out, out_idx, out_valid, wrap, in_ready);
      end
      mode  = 1'($urandom_range(0, 1));
      dwell = DWELL_W'($urandom);
      tick;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; mode = 1'b0; dwell = '0;
    test_reset;
    test_decode;
`ifdef DECODER_1HOT_SCAN_EN
    test_scan("scan_d2", 6, 2, 12);
    test_scan("scan_d0", 0, 0, 25);
    test_scan("drop_step", 0, 1, 8);
    test_scan("drop_nostep", 0, 1, 7);
    test_scan("scan_dmax", 2, 255, 600);
    test_reset_mid_scan;
    repeat (6) test_scan("scan_rand", $urandom_range(0, OUT_W - 1), $urandom_range(0, 4), $urandom_range(1, 40));
    test_decode;
`else
    test_no_scan;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_1hot_seq.md
# decoder_1hot_seq

Parametrised, registered successor of the 3-to-8 one-hot decoder. It decodes an IN_W-bit index into a 2**IN_W-bit one-hot word behind a valid/ready handshake. It also has an optional scan mode that walks the single hot bit across all outputs with a programmable dwell time. It drives one-hot select lines such as LED banks, mux selects and row strobes, and replaces the fixed combinational decoder.

## Interface
Parameters:
- IN_W, 3: index width; output width OUT_W = 2**IN_W.
- DWELL_W, 8: width of the dwell-count input.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: index on `in` is offered.
- in, input, IN_W: index to decode, or start index for a scan.
- in_ready, output, 1: block accepts an index this cycle.
- mode, input, 1: 0 = decode/hold, 1 = scan. Sampled only on accept and during SCAN.
- dwell, input, DWELL_W: extra cycles each scan position is held. Each position lasts dwell+1 cycles.
- out, output, OUT_W: registered one-hot output, or all zeros when not valid.
- out_idx, output, IN_W: binary index of the hot bit.
- out_valid, output, 1: `out` carries a hot bit.
- wrap, output, 1: one-cycle pulse when a scan steps from index OUT_W-1 to 0.

## Operation
- States are IDLE, HOLD and SCAN.
- Accept occurs when in_valid && in_ready.
- in_ready = 1 in IDLE and HOLD, and 0 in SCAN.
- IDLE:
  - Outputs are out = 0, out_valid = 0.
  - On accept with mode = 0, go to HOLD. On accept with mode = 1, go to SCAN.
- HOLD:
  - out = 1 << idx, out_valid = 1.
  - A new accept overwrites idx and re-evaluates mode, using the same transitions as IDLE.
- SCAN:
  - On entry, idx = accepted `in` and the dwell counter is loaded with `dwell`.
  - Each cycle the counter decrements. At 0, idx advances by 1 modulo OUT_W and the counter reloads from the current `dwell`.
  - The `dwell` input is re-sampled at every step.
  - On the step from idx OUT_W-1 to 0, wrap = 1 for exactly that cycle.
  - When mode = 0 is seen in SCAN, go to HOLD next cycle. The current idx and out are kept, with no step that cycle.
- Arithmetic:
  - idx is IN_W bits with natural wrap.
  - The dwell counter is DWELL_W bits, unsigned.
  - dwell = 0 means the block steps every cycle.
  - dwell = all-ones means each position is held 2**DWELL_W cycles.
- Invariants:
  - `out` is always all zeros or exactly one hot bit.
  - When out_valid = 1, out_idx equals the position of the hot bit.

## Timing
- Reset values: out = 0, out_idx = 0, out_valid = 0, wrap = 0, in_ready = 1, state IDLE, dwell counter 0.
- Reset takes priority over every other event, including mid-scan and on a wrap cycle.
- Decode latency is 1 cycle. An accept at edge N drives out, out_idx and out_valid from edge N+1.
- Scan start:
  - The first position appears at edge N+1 after the accept.
  - The first step occurs dwell+1 cycles later.
- wrap is registered and asserts in the same cycle that out shows bit 0 after bit OUT_W-1.
- in_ready is registered from state. It drops the cycle after a scan accept and rises the cycle after SCAN exits.
- Simultaneous events in SCAN:
  - mode dropping on a step cycle: exit wins, no step occurs and wrap stays 0.
  - in_valid in SCAN is ignored (in_ready = 0).

## Configuration
- DECODER_1HOT_SCAN_EN:
  - When defined, the SCAN state, dwell counter and wrap logic are compiled in as described above.
  - When undefined:
    - `mode` and `dwell` are ignored.
    - Every accept goes to HOLD.
    - in_ready is constant 1.
    - wrap is tied to 0.
    - No dwell counter is synthesised.

## Test plan
- Reset, then offer in = 0..7 with mode = 0 on consecutive cycles (IN_W = 3) -> out = 0x01, 0x02, ... 0x80, one cycle after each accept. out_valid = 1 and in_ready stays 1 throughout.
- Scan with in = 6, mode = 1, dwell = 2 -> out = 0x40 for 3 cycles, then 0x80 for 3, then 0x01. wrap pulses exactly on the 0x80 -> 0x01 cycle. in_ready = 0 during the scan.
- Scan with dwell = 0 from in = 0 -> out steps every cycle. wrap pulses once every 8 cycles.
- Drop mode in mid-scan at idx 3, both on a step cycle and on a non-step cycle -> out holds 0x08 in HOLD, wrap stays 0, and in_ready returns to 1 the next cycle.
- Assert rst during a scan at idx 7 on the step cycle -> next cycle out = 0, out_idx = 0, wrap = 0, out_valid = 0, in_ready = 1.
- Build with DECODER_1HOT_SCAN_EN undefined and offer in = 5 with mode = 1 -> out = 0x20 held, wrap never asserts, in_ready is always 1.
